// File: rtl/muldiv_ctrl_pkg.sv
// Shared funct codes for the HI/LO instruction group and a decode helper.
package muldiv_ctrl_pkg;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    localparam int unsigned WIDTH = 32;

    function automatic logic is_hilo_funct(input logic [5:0] f);
        return (f == F_MFHI) || (f == F_MTHI) || (f == F_MFLO) || (f == F_MTLO) ||
               (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer: LSB-first shift-add multiply or restoring divide.
module muldiv_step
    import muldiv_ctrl_pkg::*;
(
    input  logic              is_div,
    input  logic [WIDTH-1:0]  acc_hi,
    input  logic [WIDTH-1:0]  acc_lo,
    input  logic [WIDTH-1:0]  operand,
    output logic [WIDTH-1:0]  nxt_hi,
    output logic [WIDTH-1:0]  nxt_lo
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted_rem;
    logic [WIDTH:0] trial;
    logic           fits;

    always_comb begin
        // Multiply: add multiplicand into the high half when the multiplier LSB is set, then shift right.
        sum         = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        // Divide: shift next dividend bit into the remainder and trial-subtract the divisor.
        shifted_rem = {acc_hi, acc_lo[WIDTH-1]};
        trial       = shifted_rem - {1'b0, operand};
        fits        = (shifted_rem >= {1'b0, operand});

        if (is_div) begin
            nxt_hi = fits ? trial[WIDTH-1:0] : shifted_rem[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], fits};
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner: sequences 32-step multiply/divide, applies sign fixup, stalls dependent HI/LO ops.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] hilo_out,
    output logic        busy,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state;
    logic [31:0] hi, lo;
    logic [31:0] acc_hi, acc_lo, operand;
    logic [31:0] nxt_hi, nxt_lo;
    logic [4:0]  cnt;
    logic        is_div, neg_q, neg_r;

    logic        op_signed, op_div, div0;
    logic [31:0] rs_abs, rt_abs;
    logic [63:0] prod_neg;
    logic [31:0] quo_neg, rem_neg;

    always_comb begin
        stall     = busy && valid && is_hilo_funct(funct);
        hilo_out  = (funct == F_MFHI) ? hi : lo;
        op_signed = (funct == F_MULT) || (funct == F_DIV);
        op_div    = (funct == F_DIV) || (funct == F_DIVU);
        div0      = op_div && (rt_val == '0);
        rs_abs    = (op_signed && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
        rt_abs    = (op_signed && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;
        prod_neg  = ~{acc_hi, acc_lo} + 64'd1;
        quo_neg   = ~acc_lo + 32'd1;
        rem_neg   = ~acc_hi + 32'd1;
    end

    muldiv_step u_step (
        .is_div  (is_div),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (operand),
        .nxt_hi  (nxt_hi),
        .nxt_lo  (nxt_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            operand <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        case (funct)
                            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                                acc_hi <= '0;
                                cnt    <= '0;
                                busy   <= 1'b1;
                                is_div <= op_div;
                                state  <= CALC;
                                if (op_div) begin
                                    // Divide-by-zero runs unsigned on the raw dividend so HI ends up as rs_val.
                                    acc_lo  <= div0 ? rs_val : rs_abs;
                                    operand <= rt_abs;
                                    neg_q   <= !div0 && op_signed && (rs_val[31] ^ rt_val[31]);
                                    neg_r   <= !div0 && op_signed && rs_val[31];
                                end else begin
                                    acc_lo  <= rt_abs;
                                    operand <= rs_abs;
                                    neg_q   <= op_signed && (rs_val[31] ^ rt_val[31]);
                                    neg_r   <= 1'b0;
                                end
                            end
                            F_MTHI:  hi <= rs_val;
                            F_MTLO:  lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        lo <= neg_q ? quo_neg : acc_lo;
                        hi <= neg_r ? rem_neg : acc_hi;
                    end else begin
                        {hi, lo} <= neg_q ? prod_neg : {acc_hi, acc_lo};
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, signed/unsigned results, stalls, MTHI/MTLO, reset abort.
module tb_muldiv_ctrl;

    localparam logic [5:0] MFHI  = 6'h10;
    localparam logic [5:0] MTHI  = 6'h11;
    localparam logic [5:0] MFLO  = 6'h12;
    localparam logic [5:0] MTLO  = 6'h13;
    localparam logic [5:0] MULT  = 6'h18;
    localparam logic [5:0] MULTU = 6'h19;
    localparam logic [5:0] DIV   = 6'h1A;
    localparam logic [5:0] DIVU  = 6'h1B;
    localparam logic [5:0] ADDU  = 6'h21;
    localparam logic [5:0] SLL   = 6'h00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [5:0]  funct;
    logic [31:0] rs_val, rt_val;
    logic [31:0] hilo_out;
    logic        busy, stall;

    int compared = 0;
    int mismatched = 0;
    int n;

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (valid),
        .funct    (funct),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .hilo_out (hilo_out),
        .busy     (busy),
        .stall    (stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; inputs change and are sampled 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        valid = 1'b1;
        funct = MFHI;
        #1;
        chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
        chk({tag, "_hi"}, hilo_out, exp_hi);
        funct = MFLO;
        #1;
        chk({tag, "_lo"}, hilo_out, exp_lo);
        valid = 1'b0;
        funct = SLL;
    endtask

    // Presents the op in the current cycle (cycle 0) and leaves the bench in cycle 1.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        valid  = 1'b1;
        funct  = f;
        rs_val = a;
        rt_val = b;
        tick();
        valid  = 1'b0;
        funct  = SLL;
        #1;
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        issue(f, a, b);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            tick();
        end
        chk({tag, "_busy_cycles"}, cyc, 32'd33);
        read_hilo(tag, exp_hi, exp_lo);
        tick();
    endtask

    initial begin
        rst_n  = 1'b0;
        valid  = 1'b0;
        funct  = SLL;
        rs_val = '0;
        rt_val = '0;
        tick();
        tick();
        chk("reset_busy", {31'b0, busy}, 32'd0);
        read_hilo("reset", 32'd0, 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_neg",  MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("div_neg",   DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_zero", DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF);
        run_op("div_ovf",   DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        // Dependent MFLO from cycle 1 stalls until the result is written.
        issue(MULTU, 32'd6, 32'd7);
        valid = 1'b1;
        funct = MFLO;
        #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            tick();
        end
        chk("mflo_stall_cycles", n, 32'd33);
        chk("mflo_after_stall", hilo_out, 32'd42);
        chk("mflo_after_busy", {31'b0, busy}, 32'd0);
        valid = 1'b0;
        funct = SLL;
        tick();

        // MTHI/MTLO take effect after one edge.
        valid  = 1'b1;
        funct  = MTHI;
        rs_val = 32'h00001234;
        tick();
        funct  = MTLO;
        rs_val = 32'h0000ABCD;
        tick();
        read_hilo("mthi_mtlo", 32'h00001234, 32'h0000ABCD);
        tick();

        // Non-HI/LO op during busy, then reset aborts the divide mid-CALC.
        issue(DIVU, 32'd100, 32'd3);
        valid = 1'b1;
        funct = ADDU;
        #1;
        chk("addu_busy", {31'b0, busy}, 32'd1);
        chk("addu_no_stall", {31'b0, stall}, 32'd0);
        tick();
        valid = 1'b0;
        funct = SLL;
        for (int i = 0; i < 8; i++) tick();
        chk("pre_reset_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        read_hilo("abort", 32'd0, 32'd0);

        run_op("multu_after_abort", MULTU, 32'd2, 32'd3, 32'd0, 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
